// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue.
//   BR_RESOLVE_PACKET : one resolved branch from an execute-stage branch unit
//   BRANCH_REG_PACKET : resolution broadcast to the branch stack (bmm==0 idle)
//   mask_hit          : true when two branch masks share any bit
package branch_resolve_queue_pkg;

    localparam int unsigned BRQ_B_MASK_WIDTH = 4;
    localparam int unsigned BRQ_NUM_BR       = 2;
    localparam int unsigned BRQ_DEPTH        = BRQ_B_MASK_WIDTH;

    typedef logic [BRQ_B_MASK_WIDTH-1:0] B_MASK;

    typedef struct packed {
        B_MASK       bmm;
        B_MASK       b_m;
        logic        mispred;
        logic        taken;
        logic [31:0] target_PC;
    } BR_RESOLVE_PACKET;

    typedef struct packed {
        B_MASK       bmm;
        logic        bm_mispred;
        logic [31:0] target_PC;
        logic        taken;
    } BRANCH_REG_PACKET;

    function automatic logic mask_hit(input B_MASK a, input B_MASK b);
        return (a & b) != '0;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_select.sv
// Combinational selector for the branch resolve queue.
//   cand_valid/cand : queue slots first, then incoming entries in port order
//   squash          : candidates already killed by the branch currently on the output
//   sel             : one-hot chosen candidate
//   prune           : surviving candidates dropped because they depend on a selected mispredict
//   sel_out         : the resolution to register next (all-zero when nothing is selected)
module brq_select
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned NUM_CAND     = BRQ_DEPTH + BRQ_NUM_BR,
    parameter int unsigned B_MASK_WIDTH = BRQ_B_MASK_WIDTH
) (
    input  logic [NUM_CAND-1:0] cand_valid,
    input  BR_RESOLVE_PACKET    cand [NUM_CAND],
    input  logic [NUM_CAND-1:0] squash,
    output logic [NUM_CAND-1:0] sel,
    output logic [NUM_CAND-1:0] prune,
    output BRANCH_REG_PACKET    sel_out
);

    logic [NUM_CAND-1:0]     alive;
    logic [NUM_CAND-1:0]     oldest;
    logic                    found;
    logic [B_MASK_WIDTH-1:0] sel_bmm;

    always_comb begin
        alive  = cand_valid & ~squash;
        oldest = '0;
        sel    = '0;
        prune  = '0;
        found  = 1'b0;

        // A mispredict is the oldest one when it depends on no other live mispredict.
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            oldest[i] = alive[i] && cand[i].mispred;
            for (int unsigned j = 0; j < NUM_CAND; j++) begin
                if (j != i && alive[j] && cand[j].mispred && mask_hit(cand[i].b_m, cand[j].bmm))
                    oldest[i] = 1'b0;
            end
        end

        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (!found && oldest[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (!found && alive[i] && !cand[i].mispred) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end

        sel_out = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (sel[i]) begin
                sel_out.bmm        = cand[i].bmm;
                sel_out.bm_mispred = cand[i].mispred;
                sel_out.target_PC  = cand[i].target_PC;
                sel_out.taken      = cand[i].taken;
            end
        end
        sel_bmm = sel_out.bmm;

        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            prune[i] = alive[i] && !sel[i] && sel_out.bm_mispred && mask_hit(cand[i].b_m, sel_bmm);
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: buffers up to NUM_BR resolved branches per cycle and
// broadcasts at most one resolution per cycle to the branch stack.
//   clock, reset      : single clock, synchronous active-high reset
//   ex_branch_valid   : per-unit resolve valid (ignored while brq_ready is low)
//   ex_branch         : per-unit resolved branch
//   brq_ready         : registered; NUM_BR free slots exist this cycle
//   branch_completing : registered resolution, bmm==0 when idle
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned NUM_BR       = BRQ_NUM_BR,
    parameter int unsigned DEPTH        = BRQ_DEPTH,
    parameter int unsigned B_MASK_WIDTH = BRQ_B_MASK_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BR-1:0]   ex_branch_valid,
    input  BR_RESOLVE_PACKET    ex_branch [NUM_BR],
    output logic                brq_ready,
    output BRANCH_REG_PACKET    branch_completing
);

    localparam int unsigned NUM_CAND = DEPTH + NUM_BR;

    logic [DEPTH-1:0]    q_valid;
    BR_RESOLVE_PACKET    q_entry [DEPTH];

    logic [NUM_CAND-1:0] cand_valid;
    BR_RESOLVE_PACKET    cand [NUM_CAND];
    logic [NUM_CAND-1:0] squash;
    logic [NUM_CAND-1:0] sel;
    logic [NUM_CAND-1:0] prune;
    logic [NUM_CAND-1:0] keep;
    BRANCH_REG_PACKET    sel_out;
    BR_RESOLVE_PACKET    pruned [NUM_CAND];

    logic [DEPTH-1:0]    n_valid;
    BR_RESOLVE_PACKET    n_entry [DEPTH];
    logic                placed;
    int unsigned         next_count;
    logic                n_ready;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cand[i]       = q_entry[i];
            cand_valid[i] = q_valid[i];
        end
        for (int unsigned k = 0; k < NUM_BR; k++) begin
            cand[DEPTH+k]       = ex_branch[k];
            cand_valid[DEPTH+k] = ex_branch_valid[k] && brq_ready;
        end
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            squash[i] = (branch_completing.bmm != '0) &&
                        ((branch_completing.bm_mispred && mask_hit(cand[i].b_m, branch_completing.bmm)) ||
                         (cand[i].bmm == branch_completing.bmm));
        end
    end

    brq_select #(
        .NUM_CAND     (NUM_CAND),
        .B_MASK_WIDTH (B_MASK_WIDTH)
    ) u_select (
        .cand_valid (cand_valid),
        .cand       (cand),
        .squash     (squash),
        .sel        (sel),
        .prune      (prune),
        .sel_out    (sel_out)
    );

    always_comb begin
        keep = cand_valid & ~squash & ~sel & ~prune;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            pruned[i] = cand[i];
            if (!sel_out.bm_mispred)
                pruned[i].b_m = cand[i].b_m & ~sel_out.bmm;
        end

        // Stored entries stay in their slots; incoming survivors fill the
        // lowest free slots, which includes a slot vacated this cycle.
        for (int unsigned s = 0; s < DEPTH; s++) begin
            n_valid[s] = keep[s];
            n_entry[s] = pruned[s];
        end
        for (int unsigned k = 0; k < NUM_BR; k++) begin
            placed = 1'b0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (keep[DEPTH+k] && !placed && !n_valid[s]) begin
                    n_valid[s] = 1'b1;
                    n_entry[s] = pruned[DEPTH+k];
                    placed     = 1'b1;
                end
            end
        end

        next_count = 0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (n_valid[s])
                next_count = next_count + 1;
        end
        n_ready = (DEPTH - next_count) >= NUM_BR;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_valid           <= '0;
            branch_completing <= '0;
            brq_ready         <= 1'b1;
        end else begin
            q_valid           <= n_valid;
            branch_completing <= sel_out;
            brq_ready         <= n_ready;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
            q_entry[s] <= n_entry[s];
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (NUM_BR=2, DEPTH=4, 4-bit masks).
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    logic             clock;
    logic             reset;
    logic [1:0]       ex_branch_valid;
    BR_RESOLVE_PACKET ex_branch [2];
    logic             brq_ready;
    BRANCH_REG_PACKET branch_completing;

    BRANCH_REG_PACKET exp;
    int               checks;
    int               errors;

    branch_resolve_queue #(
        .NUM_BR       (2),
        .DEPTH        (4),
        .B_MASK_WIDTH (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ex_branch_valid   (ex_branch_valid),
        .ex_branch         (ex_branch),
        .brq_ready         (brq_ready),
        .branch_completing (branch_completing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        assert (reset || brq_ready || ex_branch_valid == 2'b00)
            else $error("FAIL protocol: ex_branch_valid=%b while brq_ready=0", ex_branch_valid);
    end

    function automatic BRANCH_REG_PACKET mk(input logic [3:0] bmm, input logic mis,
                                            input logic [31:0] pc, input logic tk);
        BRANCH_REG_PACKET p;
        p.bmm        = bmm;
        p.bm_mispred = mis;
        p.target_PC  = pc;
        p.taken      = tk;
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        ex_branch_valid = 2'b00;
        ex_branch[0]    = '0;
        ex_branch[1]    = '0;
    endtask

    task automatic drive(input int k, input logic [3:0] bmm, input logic [3:0] bm,
                         input logic mis, input logic tk, input logic [31:0] pc);
        ex_branch[k].bmm       = bmm;
        ex_branch[k].b_m       = bm;
        ex_branch[k].mispred   = mis;
        ex_branch[k].taken     = tk;
        ex_branch[k].target_PC = pc;
        ex_branch_valid[k]     = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_in();
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (branch_completing !== '0) begin
                errors++;
                $display("FAIL reset_idle_out cycle %0d got %h want 0", c, branch_completing);
            end
            checks++;
            if (brq_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle_ready cycle %0d got %b want 1", c, brq_ready);
            end
        end
    endtask

    task automatic test_single();
        drive(0, 4'b0001, 4'b0000, 1'b0, 1'b1, 32'h100);
        tick();
        clear_in();
        exp = mk(4'b0001, 1'b0, 32'h100, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL single_emit got %h want %h", branch_completing, exp);
        end
        tick();
        checks++;
        if (branch_completing !== '0) begin
            errors++;
            $display("FAIL single_idle got %h want 0", branch_completing);
        end
        checks++;
        if (brq_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b want 1", brq_ready);
        end
    endtask

    task automatic test_mispred_first();
        drive(0, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'h300);
        drive(1, 4'b0010, 4'b0001, 1'b1, 1'b1, 32'h340);
        tick();
        clear_in();
        exp = mk(4'b0010, 1'b1, 32'h340, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL mispred_first_c1 got %h want %h", branch_completing, exp);
        end
        tick();
        exp = mk(4'b0001, 1'b0, 32'h300, 1'b0);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL mispred_first_c2 got %h want %h", branch_completing, exp);
        end
        tick();
        checks++;
        if (branch_completing !== '0) begin
            errors++;
            $display("FAIL mispred_first_c3 got %h want 0", branch_completing);
        end
    endtask

    task automatic test_two_mispred();
        drive(0, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h400);
        drive(1, 4'b0100, 4'b0001, 1'b1, 1'b1, 32'h440);
        tick();
        clear_in();
        exp = mk(4'b0001, 1'b1, 32'h400, 1'b0);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL two_mispred_c1 got %h want %h", branch_completing, exp);
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            checks++;
            if (branch_completing !== '0) begin
                errors++;
                $display("FAIL two_mispred_c%0d got %h want 0", c, branch_completing);
            end
        end
    endtask

    task automatic test_indep_mispred();
        drive(0, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'h480);
        drive(1, 4'b0010, 4'b0000, 1'b1, 1'b0, 32'h4C0);
        tick();
        clear_in();
        exp = mk(4'b0001, 1'b1, 32'h480, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL indep_c1 got %h want %h", branch_completing, exp);
        end
        tick();
        exp = mk(4'b0010, 1'b1, 32'h4C0, 1'b0);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL indep_c2 got %h want %h", branch_completing, exp);
        end
        tick();
        checks++;
        if (branch_completing !== '0) begin
            errors++;
            $display("FAIL indep_c3 got %h want 0", branch_completing);
        end
    endtask

    task automatic test_prune();
        // Correct 0001 clears that bit from the queued 0100 (b_m 0011 -> 0010).
        drive(0, 4'b0001, 4'b0000, 1'b0, 1'b1, 32'h500);
        drive(1, 4'b0100, 4'b0011, 1'b0, 1'b0, 32'h540);
        tick();
        clear_in();
        exp = mk(4'b0001, 1'b0, 32'h500, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL prune_correct got %h want %h", branch_completing, exp);
        end
        drive(0, 4'b1000, 4'b0000, 1'b1, 1'b1, 32'h580);
        tick();
        clear_in();
        exp = mk(4'b1000, 1'b1, 32'h580, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL prune_unrelated_mis got %h want %h", branch_completing, exp);
        end
        // Reused tag 0001 mispredicts; 0100 survives only if its 0001 bit was cleared.
        drive(0, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'h5C0);
        tick();
        clear_in();
        exp = mk(4'b0001, 1'b1, 32'h5C0, 1'b0);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL prune_reuse_mis got %h want %h", branch_completing, exp);
        end
        tick();
        exp = mk(4'b0100, 1'b0, 32'h540, 1'b0);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL prune_cleared_survivor got %h want %h", branch_completing, exp);
        end
        tick();
        checks++;
        if (branch_completing !== '0) begin
            errors++;
            $display("FAIL prune_idle got %h want 0", branch_completing);
        end
        // Mispredict 0010 drops the dependent 0100 arriving alongside it.
        drive(0, 4'b0100, 4'b0010, 1'b0, 1'b1, 32'h600);
        drive(1, 4'b0010, 4'b0000, 1'b1, 1'b1, 32'h640);
        tick();
        clear_in();
        exp = mk(4'b0010, 1'b1, 32'h640, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL prune_mis_emit got %h want %h", branch_completing, exp);
        end
        tick();
        checks++;
        if (branch_completing !== '0) begin
            errors++;
            $display("FAIL prune_dependent_dropped got %h want 0", branch_completing);
        end
    endtask

    task automatic test_fill_drain_reset();
        drive(0, 4'b0001, 4'b0000, 1'b0, 1'b1, 32'h700);
        drive(1, 4'b0010, 4'b0000, 1'b0, 1'b1, 32'h704);
        tick();
        exp = mk(4'b0001, 1'b0, 32'h700, 1'b1);
        checks++;
        if (branch_completing !== exp || brq_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_c1 got %h/%b want %h/1", branch_completing, brq_ready, exp);
        end
        drive(0, 4'b0100, 4'b0000, 1'b0, 1'b1, 32'h708);
        drive(1, 4'b1000, 4'b0000, 1'b0, 1'b1, 32'h70C);
        tick();
        exp = mk(4'b0010, 1'b0, 32'h704, 1'b1);
        checks++;
        if (branch_completing !== exp || brq_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_c2 got %h/%b want %h/1", branch_completing, brq_ready, exp);
        end
        drive(0, 4'b0001, 4'b0000, 1'b0, 1'b1, 32'h710);
        drive(1, 4'b1000, 4'b0000, 1'b0, 1'b1, 32'h714);
        tick();
        clear_in();
        exp = mk(4'b0100, 1'b0, 32'h708, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL fill_c3_out got %h want %h", branch_completing, exp);
        end
        checks++;
        if (brq_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_c3_ready got %b want 0", brq_ready);
        end
        tick();
        exp = mk(4'b0001, 1'b0, 32'h710, 1'b1);
        checks++;
        if (branch_completing !== exp) begin
            errors++;
            $display("FAIL drain_c4_out got %h want %h", branch_completing, exp);
        end
        checks++;
        if (brq_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_c4_ready got %b want 1", brq_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (branch_completing !== '0 || brq_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_c5 got %h/%b want 0/1", branch_completing, brq_ready);
        end
        for (int c = 6; c <= 7; c++) begin
            tick();
            checks++;
            if (branch_completing !== '0) begin
                errors++;
                $display("FAIL midreset_c%0d got %h want 0", c, branch_completing);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_in();
        test_reset();
        test_single();
        test_mispred_first();
        test_two_mispred();
        test_indep_mispred();
        test_prune();
        test_fill_drain_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between the execute-stage branch units and the branch stack, and is the sole driver of branch_completing (BRANCH_REG_PACKET).
- Accepts up to NUM_BR resolved branches per cycle and buffers them.
- Emits at most one resolution per cycle, from a register.
- Handles ordering and squash locally: mispredicts go first, and entries made stale by an emitted mispredict or correct resolve are pruned.

Parameters:
- NUM_BR, 2, branch units feeding the queue per cycle.
- DEPTH, `B_MASK_WIDTH, queue entries. Must be >= NUM_BR.
- B_MASK_WIDTH, `B_MASK_WIDTH, branch mask width. Taken from sys_defs.

Ports:
- clock  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high.
- ex_branch_valid  in  NUM_BR  per-unit resolve valid.
- ex_branch  in  NUM_BR x BR_RESOLVE_PACKET  fields: bmm (one-hot own bit), b_m (masks of older branches it depends on), mispred, taken, target_PC.
- brq_ready  out  1  queue can accept NUM_BR entries next cycle. Registered.
- branch_completing  out  BRANCH_REG_PACKET  fields: bmm, bm_mispred, target_PC, taken. bmm==0 means idle. Registered.

Behaviour:
- Reset: queue empty, count=0, branch_completing all-zero, brq_ready=1 (DEPTH>=NUM_BR).
- Entry state: valid, bmm, b_m, mispred, taken, target_PC.
- Candidate set each cycle:
  - all valid queue entries plus all valid incoming ex_branch entries;
  - minus any candidate killed by the squash set S.
- Squash set S:
  - If current branch_completing.bm_mispred and bmm!=0: kill any candidate with b_m & branch_completing.bmm != 0.
  - Also kill any candidate with bmm == branch_completing.bmm (a duplicate).
- Selection, one per cycle:
  1. A mispredicted candidate whose b_m intersects no other surviving mispredicted candidate's bmm (the oldest mispredict).
  2. Otherwise, the correct-predict candidate at the lowest slot index. Queue slots come first, then incoming in port order.
- Emit: the selected candidate is registered onto branch_completing at the next edge (latency 1 from arrival when the queue is empty). With no candidate, branch_completing.bmm <= 0.
- Pruning at the same edge, applied to all non-selected survivors (queue and incoming):
  - If the selected candidate is mispredicted: drop those with b_m & sel.bmm != 0.
  - If it is correct: clear sel.bmm from their b_m.
- Enqueue: surviving non-selected incoming entries are written to free slots, lowest free index first.
- Count: next_count = survivors stored. Never exceeds DEPTH.
- brq_ready <= (DEPTH - next_count) >= NUM_BR.
- Sender must not assert ex_branch_valid while brq_ready==0. Input in that state is dropped; the bench flags it with an assertion.
- Simultaneous cases:
  - An incoming branch younger than the mispredict being emitted is dropped the same cycle; it is never enqueued.
  - Two mispredicts in one cycle: only the oldest is emitted. The younger is pruned if dependent on it.
  - Independent mispredicts (disjoint masks) emit on consecutive cycles.
- Full queue with no input: drains one entry per cycle. brq_ready rises once free slots >= NUM_BR.
- Reset mid-operation: queue and output cleared next edge. No partial emission.
- The output is a pure register, never combinational from ex_branch.

Decomposition:
- sys_defs gets:
  - BR_RESOLVE_PACKET typedef;
  - `BRQ_DEPTH and `NUM_BR defines.
- BRANCH_REG_PACKET, B_MASK and B_MASK_MASK are already in sys_defs and are reused as-is.
- One natural sub-module: brq_select. Purely combinational: candidate vector plus squash mask in, one-hot select and prune masks out. Unit-testable alone.

Test Plan (B_MASK_WIDTH=4, NUM_BR=2, DEPTH=4):
1. Reset, then idle 3 cycles -> branch_completing.bmm=0, brq_ready=1, count=0.
2. Single correct branch, bmm=0001, b_m=0000, cycle 0 -> cycle 1: bmm=0001, bm_mispred=0. Cycle 2: bmm=0.
3. Same cycle: bmm=0001 correct and bmm=0010 mispred (b_m=0001) -> 0010 mispred emitted cycle 1 (mispred priority), 0001 emitted cycle 2.
4. Same cycle: mispred bmm=0001 (b_m=0) and mispred bmm=0100 (b_m=0001) -> only 0001 emitted. 0100 is pruned and never appears. Queue empty at cycle 2.
5. Queue holds {0010, b_m=0001} and {0100, b_m=0011}; emit correct 0001 -> both remain with b_m 0000 and 0010. Emit mispred 0010 next -> 0100 dropped.
6. Fill queue to 4 with correct branches -> brq_ready=0 after count>2. Drain one per cycle; brq_ready=1 once count<=2. Reset asserted mid-drain clears all outputs next cycle.
